// File: rtl/regfile_wb_queue.sv
// Write-back FIFO in front of the register file write port.
// Optional read-hazard lookup is built when WB_HAZARD_EN is defined.
module regfile_wb_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          Reset,
   input  logic          Flush,
   input  logic          Hold,
   input  logic          In_Valid,
   output logic          In_Ready,
   input  logic [4:0]    In_Addr,
   input  logic [31:0]   In_Data,
   output logic [4:0]    W_Addr,
   output logic [31:0]   W_Data,
   output logic          Write_Reg,
   output logic [CW-1:0] Count,
   input  logic [4:0]    R_Addr_A,
   input  logic [4:0]    R_Addr_B,
   output logic          Pending_A,
   output logic          Pending_B
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [4:0]    addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;

   assign Count     = count;
   assign In_Ready  = (count != CW'(DEPTH));
   assign Write_Reg = (count != '0) && !Hold;
   assign push      = In_Valid && In_Ready;
   assign pop       = Write_Reg;

   assign W_Addr = Write_Reg ? addr_q[rd_ptr] : 5'd0;
   assign W_Data = Write_Reg ? data_q[rd_ptr] : 32'd0;

   always_ff @(posedge clk) begin
      if (Reset || Flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   // Payload storage needs no reset; occupancy gates every use.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr] <= In_Addr;
         data_q[wr_ptr] <= In_Data;
      end
   end

`ifdef WB_HAZARD_EN
   logic [PW-1:0] slot;

   always_comb begin
      Pending_A = 1'b0;
      Pending_B = 1'b0;
      slot      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         slot = rd_ptr + PW'(k);
         if (CW'(k) < count) begin
            if (addr_q[slot] == R_Addr_A)
               Pending_A = 1'b1;
            if (addr_q[slot] == R_Addr_B)
               Pending_B = 1'b1;
         end
      end
   end
`else
   logic unused_raddr;

   assign unused_raddr = ^{R_Addr_A, R_Addr_B};
   assign Pending_A    = 1'b0;
   assign Pending_B    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue against a queue-based model.
module tb_regfile_wb_queue;

   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          Reset, Flush, Hold, In_Valid;
   logic          In_Ready, Write_Reg, Pending_A, Pending_B;
   logic [4:0]    In_Addr, W_Addr, R_Addr_A, R_Addr_B;
   logic [31:0]   In_Data, W_Data;
   logic [CW-1:0] Count;

   logic [36:0] exp_q [$];
   logic [31:0] rf_seen [32];
   bit          checking = 1'b0;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   always #5 clk = ~clk;

   regfile_wb_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .Reset(Reset), .Flush(Flush), .Hold(Hold),
      .In_Valid(In_Valid), .In_Ready(In_Ready),
      .In_Addr(In_Addr), .In_Data(In_Data),
      .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
      .Count(Count), .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
      .Pending_A(Pending_A), .Pending_B(Pending_B)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      total_cnt++;
      if (act === req)
         pass_cnt++;
      else
         $display("FAIL %s at %0t: got %0h expected %0h",
                  nm, $time, act, req);
   endtask

   // Issue one cycle of stimulus and record what the queue must hold
   // after the coming edge.
   task automatic drive(input logic v, input logic [4:0] a,
                        input logic [31:0] d, input logic h,
                        input logic f, input logic r,
                        input logic [4:0] ra, input logic [4:0] rb);
      bit rdy;
      @(negedge clk);
      rdy      = exp_q.size() < DEPTH;
      In_Valid = v;
      In_Addr  = a;
      In_Data  = d;
      Hold     = h;
      Flush    = f;
      Reset    = r;
      R_Addr_A = ra;
      R_Addr_B = rb;
      #4;
      if (r || f)
         exp_q.delete();
      else if (v && rdy)
         exp_q.push_back({a, d});
   endtask

   task automatic idle(input logic h, input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, 5'd0, 32'd0, h, 1'b0, 1'b0, 5'd9, 5'd3);
   endtask

   // Monitor: compares DUT outputs with the model mid-cycle and
   // retires the head whenever a write is expected.
   always begin
      int  sz;
      bit  wr_exp, pa, pb;
      @(negedge clk);
      #2;
      if (checking) begin
         sz     = exp_q.size();
         wr_exp = (sz != 0) && !Hold;
         chk("count", 64'(Count), 64'(sz));
         chk("in_ready", 64'(In_Ready), 64'(sz < DEPTH));
         chk("write_reg", 64'(Write_Reg), 64'(wr_exp));
         pa = 1'b0;
         pb = 1'b0;
`ifdef WB_HAZARD_EN
         foreach (exp_q[i]) begin
            if (exp_q[i][36:32] == R_Addr_A) pa = 1'b1;
            if (exp_q[i][36:32] == R_Addr_B) pb = 1'b1;
         end
`endif
         chk("pending_a", 64'(Pending_A), 64'(pa));
         chk("pending_b", 64'(Pending_B), 64'(pb));
         if (wr_exp) begin
            chk("w_addr", 64'(W_Addr), 64'(exp_q[0][36:32]));
            chk("w_data", 64'(W_Data), 64'(exp_q[0][31:0]));
            rf_seen[W_Addr] = W_Data;
            void'(exp_q.pop_front());
         end else begin
            chk("w_addr_idle", 64'(W_Addr), 64'd0);
            chk("w_data_idle", 64'(W_Data), 64'd0);
         end
      end
   end

   initial begin
      logic [4:0]  ra, rb, a;
      logic [31:0] d;
      logic        v, h, f, r;
      Reset = 1'b1; Flush = 1'b0; Hold = 1'b0; In_Valid = 1'b0;
      In_Addr = '0; In_Data = '0; R_Addr_A = '0; R_Addr_B = '0;
      foreach (rf_seen[i]) rf_seen[i] = '0;

      drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0);
      checking = 1'b1;
      idle(1'b0, 2);

      // single push
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0);
      idle(1'b0, 3);

      // fill while held, fifth push refused, then drain
      for (int i = 1; i <= 5; i++)
         drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0, 5'd2, 5'd5);
      idle(1'b1, 1);
      idle(1'b0, 6);

      // streaming across pointer wrap
      for (int i = 0; i < 12; i++)
         drive(1'b1, 5'(i + 10), 32'hA000 + 32'(i), 1'b0, 1'b0, 1'b0,
               5'd11, 5'd12);
      idle(1'b0, 3);

      // same address twice, last wins
      drive(1'b1, 5'd7, 32'h1, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0);
      drive(1'b1, 5'd7, 32'h2, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0);
      idle(1'b0, 3);
      chk("rf7_last_wins", 64'(rf_seen[7]), 64'h2);

      // flush, then reset, each with a simultaneous push
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 3; i++)
            drive(1'b1, 5'(20 + i), 32'(i), 1'b1, 1'b0, 1'b0, 5'd20, 5'd22);
         drive(1'b1, 5'd30, 32'h33, 1'b1, k == 0, k == 1, 5'd30, 5'd21);
         idle(1'b0, 3);
      end

      // hazard lookup across a held then released entry
      drive(1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 1'b0, 5'd9, 5'd3);
      idle(1'b1, 2);
      idle(1'b0, 3);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         v  = ($urandom_range(0, 3) != 0);
         h  = ($urandom_range(0, 3) == 0);
         f  = ($urandom_range(0, 40) == 0);
         r  = ($urandom_range(0, 80) == 0);
         a  = 5'($urandom_range(0, 7));
         d  = $urandom;
         ra = 5'($urandom_range(0, 7));
         rb = 5'($urandom_range(0, 7));
         if (f || r) h = 1'b1;
         drive(v, a, d, h, f, r, ra, rb);
      end
      idle(1'b0, 6);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
